line_buffer_ctrl: RTL and testbench

Sequencer for the two-tap line shift register used in 3x3 neighbourhood filters. Accepts a raster pixel stream and counts column/row. Drives the shift register's data/enable inputs and aligns its two line taps with the current pixel into a vertical 3-pixel window column. Emits window valid and coordinates to the downstream filter stage, plus an end-of-frame pulse.

---
 rtl/line_buffer_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl.sv
// Raster sequencer for a two-tap line shift register feeding a 3x3 window filter.
// Define LINE_BUFFER_CTRL_FLUSH_EN to add a FLUSH state that pushes one zero line after each frame.
module line_buffer_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_WIDTH-1:0]         pix_in,
   input  logic                          pix_in_valid,
   input  logic                          pix_in_sof,
   output logic                          pix_in_ready,
   output logic [DATA_WIDTH-1:0]         shiftin,
   output logic                          shiftin_valid,
   input  logic [DATA_WIDTH-1:0]         taps1x,
   input  logic [DATA_WIDTH-1:0]         taps0x,
   output logic [DATA_WIDTH-1:0]         win_top,
   output logic [DATA_WIDTH-1:0]         win_mid,
   output logic [DATA_WIDTH-1:0]         win_bot,
   output logic                          win_valid,
   output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
   output logic [$clog2(IMG_HEIGHT)-1:0] win_y,
   output logic                          frame_done
);

   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);
   localparam logic [XW-1:0] COL_ZERO = XW'(0);
   localparam logic [XW-1:0] COL_ONE  = XW'(1);
   localparam logic [XW-1:0] COL_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] ROW_ZERO = YW'(0);
   localparam logic [YW-1:0] ROW_ONE  = YW'(1);
   localparam logic [YW-1:0] ROW_TWO  = YW'(2);
   localparam logic [YW-1:0] ROW_LAST = YW'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   state_t                state_r, state_nx_s, adv_state_s;
   logic [XW-1:0]         col_r, col_nx_s, pcol_s, adv_col_s, wx_s;
   logic [YW-1:0]         row_r, row_nx_s, prow_s, adv_row_s, wy_s;
   logic                  acc_s, fwd_s, win_s, wlast_s, last_pix_s;
   logic [DATA_WIDTH-1:0] fwd_pix_s;

   logic                  s1_win_r, s1_last_r;
   logic [XW-1:0]         s1_x_r, s2_x_r;
   logic [YW-1:0]         s1_y_r, s2_y_r;
   logic                  s2_valid_r, s2_last_r, win_last_r;
   logic [DATA_WIDTH-1:0] s2_pix_r;

`ifdef LINE_BUFFER_CTRL_FLUSH_EN
   logic ready_r;
   assign pix_in_ready = ready_r;
`else
   assign pix_in_ready = 1'b1;
`endif

   // Next-state, counter advance and forwarding decision for the pixel offered this cycle
   always_comb begin
      acc_s       = pix_in_valid & pix_in_ready;
      state_nx_s  = state_r;
      col_nx_s    = col_r;
      row_nx_s    = row_r;
      fwd_s       = 1'b0;
      fwd_pix_s   = pix_in;
      win_s       = 1'b0;
      wlast_s     = 1'b0;
      wx_s        = col_r;
      wy_s        = row_r;
      // A start-of-frame pixel always lands at (0,0), whatever the counters hold
      pcol_s      = pix_in_sof ? COL_ZERO : col_r;
      prow_s      = pix_in_sof ? ROW_ZERO : row_r;
      last_pix_s  = (pcol_s == COL_LAST) && (prow_s == ROW_LAST);
      adv_col_s   = (pcol_s == COL_LAST) ? COL_ZERO : (pcol_s + COL_ONE);
      adv_row_s   = (pcol_s == COL_LAST) ? (prow_s + ROW_ONE) : prow_s;
      if (last_pix_s) begin
`ifdef LINE_BUFFER_CTRL_FLUSH_EN
         adv_state_s = ST_FLUSH;
`else
         adv_state_s = ST_IDLE;
`endif
      end else if (adv_row_s >= ROW_TWO) begin
         adv_state_s = ST_RUN;
      end else begin
         adv_state_s = ST_FILL;
      end

      case (state_r)
         ST_IDLE: begin
            if (acc_s && pix_in_sof) begin
               fwd_s      = 1'b1;
               col_nx_s   = adv_col_s;
               row_nx_s   = adv_row_s;
               state_nx_s = adv_state_s;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_FILL, ST_RUN: begin
            if (acc_s) begin
               fwd_s      = 1'b1;
               win_s      = (prow_s >= ROW_TWO);
               wx_s       = pcol_s;
               wy_s       = prow_s - ROW_ONE;
`ifdef LINE_BUFFER_CTRL_FLUSH_EN
               wlast_s    = 1'b0;
`else
               wlast_s    = last_pix_s;
`endif
               col_nx_s   = last_pix_s ? COL_ZERO : adv_col_s;
               row_nx_s   = last_pix_s ? ROW_ZERO : adv_row_s;
               state_nx_s = adv_state_s;
            end else begin
               state_nx_s = state_r;
            end
         end
         ST_FLUSH: begin
`ifdef LINE_BUFFER_CTRL_FLUSH_EN
            fwd_s      = 1'b1;
            fwd_pix_s  = {DATA_WIDTH{1'b0}};
            win_s      = 1'b1;
            wx_s       = col_r;
            wy_s       = ROW_LAST;
            wlast_s    = (col_r == COL_LAST);
            col_nx_s   = (col_r == COL_LAST) ? COL_ZERO : (col_r + COL_ONE);
            state_nx_s = (col_r == COL_LAST) ? ST_IDLE : ST_FLUSH;
`else
            state_nx_s = ST_IDLE;
`endif
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State, counters and ready flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         col_r   <= COL_ZERO;
         row_r   <= ROW_ZERO;
`ifdef LINE_BUFFER_CTRL_FLUSH_EN
         ready_r <= 1'b1;
`endif
      end else begin
         state_r <= state_nx_s;
         col_r   <= col_nx_s;
         row_r   <= row_nx_s;
`ifdef LINE_BUFFER_CTRL_FLUSH_EN
         ready_r <= (state_nx_s != ST_FLUSH);
`endif
      end
   end

   // Stage 1: drive the shift register and remember the window tag of the forwarded pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shiftin       <= {DATA_WIDTH{1'b0}};
         shiftin_valid <= 1'b0;
         s1_win_r      <= 1'b0;
         s1_last_r     <= 1'b0;
         s1_x_r        <= COL_ZERO;
         s1_y_r        <= ROW_ZERO;
      end else begin
         shiftin_valid <= fwd_s;
         if (fwd_s) begin
            shiftin   <= fwd_pix_s;
            s1_win_r  <= win_s;
            s1_last_r <= wlast_s;
            s1_x_r    <= wx_s;
            s1_y_r    <= wy_s;
         end
      end
   end

   // Stage 2: hold the current pixel while the taps settle on the shifted line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         s2_last_r  <= 1'b0;
         s2_pix_r   <= {DATA_WIDTH{1'b0}};
         s2_x_r     <= COL_ZERO;
         s2_y_r     <= ROW_ZERO;
      end else begin
         s2_valid_r <= shiftin_valid & s1_win_r;
         if (shiftin_valid) begin
            s2_last_r <= s1_last_r;
            s2_pix_r  <= shiftin;
            s2_x_r    <= s1_x_r;
            s2_y_r    <= s1_y_r;
         end
      end
   end

   // Stage 3: capture the vertical window column and the end-of-frame pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_valid  <= 1'b0;
         win_last_r <= 1'b0;
         win_top    <= {DATA_WIDTH{1'b0}};
         win_mid    <= {DATA_WIDTH{1'b0}};
         win_bot    <= {DATA_WIDTH{1'b0}};
         win_x      <= COL_ZERO;
         win_y      <= ROW_ZERO;
         frame_done <= 1'b0;
      end else begin
         win_valid  <= s2_valid_r;
         win_last_r <= s2_valid_r & s2_last_r;
         frame_done <= win_valid & win_last_r;
         if (s2_valid_r) begin
            win_top <= taps0x;
            win_mid <= taps1x;
            win_bot <= s2_pix_r;
            win_x   <= s2_x_r;
            win_y   <= s2_y_r;
         end
      end
   end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Scoreboard bench for line_buffer_ctrl on a 4x4 image with a behavioural two-tap shift register.
// The image-level reference model honours LINE_BUFFER_CTRL_FLUSH_EN like the design.
module tb_line_buffer_ctrl;

   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 4;
`ifdef LINE_BUFFER_CTRL_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] pix_in = '0;
   logic          pix_in_valid = 1'b0;
   logic          pix_in_sof = 1'b0;
   logic          pix_in_ready;
   logic [DW-1:0] shiftin;
   logic          shiftin_valid;
   logic [DW-1:0] taps1x, taps0x;
   logic [DW-1:0] win_top, win_mid, win_bot;
   logic          win_valid;
   logic [1:0]    win_x;
   logic [1:0]    win_y;
   logic          frame_done;

   line_buffer_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_in_valid(pix_in_valid),
      .pix_in_sof(pix_in_sof), .pix_in_ready(pix_in_ready), .shiftin(shiftin),
      .shiftin_valid(shiftin_valid), .taps1x(taps1x), .taps0x(taps0x),
      .win_top(win_top), .win_mid(win_mid), .win_bot(win_bot), .win_valid(win_valid),
      .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // External line shift register: taps1x is W shifts old, taps0x is 2W shifts old
   logic [DW-1:0] sr [0:2*W] = '{default: '0};
   always @(posedge clk) begin
      if (shiftin_valid) begin
         sr[0] <= shiftin;
         for (int i = 1; i <= 2 * W; i++) sr[i] <= sr[i-1];
      end
   end
   assign taps1x = sr[W];
   assign taps0x = sr[2*W];

   typedef struct {int cyc; int x; int y; int top; int mid; int bot; bit last;} win_t;
   typedef struct {int cyc; int d;} sh_t;
   win_t wq[$];
   sh_t  sq[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit in_reset = 1'b1;
   bit exp_fd = 1'b0;

   int m_phase = 0;   // 0 idle, 1 in frame, 2 flushing
   int m_col = 0, m_row = 0, m_fc = 0;
   int img [H][W];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Reference model: decides acceptance per image rules and predicts every output event
   initial forever begin
      @(negedge clk);
      if (!in_reset) begin
         int  k;
         bit  lastp;
         win_t w;
         sh_t  s;
         k = cyc + 1;
         chk("pix_in_ready", pix_in_ready, (m_phase != 2));
         if (m_phase == 2) begin
            s.cyc = k; s.d = 0; sq.push_back(s);
            w.cyc = k + 2; w.x = m_fc; w.y = H - 1;
            w.top = img[H-2][m_fc]; w.mid = img[H-1][m_fc]; w.bot = 0; w.last = (m_fc == W - 1);
            wq.push_back(w);
            m_fc++;
            if (m_fc == W) m_phase = 0;
         end else if (pix_in_valid) begin
            if (pix_in_sof) begin
               m_col = 0; m_row = 0; m_phase = 1;
            end
            if (m_phase == 1) begin
               img[m_row][m_col] = int'(pix_in);
               s.cyc = k; s.d = int'(pix_in); sq.push_back(s);
               lastp = (m_col == W - 1) && (m_row == H - 1);
               if (m_row >= 2) begin
                  w.cyc = k + 2; w.x = m_col; w.y = m_row - 1;
                  w.top = img[m_row-2][m_col]; w.mid = img[m_row-1][m_col]; w.bot = int'(pix_in);
                  w.last = lastp && !FLUSH_EN;
                  wq.push_back(w);
               end
               if (lastp) begin
                  m_phase = FLUSH_EN ? 2 : 0;
                  m_fc = 0;
               end else if (m_col == W - 1) begin
                  m_col = 0; m_row++;
               end else begin
                  m_col++;
               end
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents shiftin / window / frame_done
   initial forever begin
      @(negedge clk);
      if (!in_reset) begin
         win_t w;
         sh_t  s;
         if (sq.size() > 0 && sq[0].cyc < cyc) begin
            s = sq.pop_front();
            chk("shiftin_missing", 0, 1);
         end
         if (wq.size() > 0 && wq[0].cyc < cyc) begin
            w = wq.pop_front();
            chk("window_missing", 0, 1);
         end
         if (shiftin_valid) begin
            if (sq.size() == 0) begin
               chk("shiftin_unexpected", 1, 0);
            end else begin
               s = sq.pop_front();
               chk("shiftin_cycle", cyc, s.cyc);
               chk("shiftin_data", shiftin, s.d);
            end
         end
         chk("frame_done", frame_done, exp_fd);
         exp_fd = 1'b0;
         if (win_valid) begin
            if (wq.size() == 0) begin
               chk("window_unexpected", 1, 0);
            end else begin
               w = wq.pop_front();
               chk("win_cycle", cyc, w.cyc);
               chk("win_x", win_x, w.x);
               chk("win_y", win_y, w.y);
               chk("win_top", win_top, w.top);
               chk("win_mid", win_mid, w.mid);
               chk("win_bot", win_bot, w.bot);
               exp_fd = w.last;
            end
         end
      end
   end

   task automatic check_zero();
      chk("rst_shiftin", shiftin, 0);
      chk("rst_shiftin_valid", shiftin_valid, 0);
      chk("rst_win_valid", win_valid, 0);
      chk("rst_win_data", {win_top, win_mid, win_bot}, 0);
      chk("rst_win_xy", {win_x, win_y}, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_ready", pix_in_ready, 1);
   endtask

   // Offer one pixel until accepted, then idle for gap cycles; entered #1 after a posedge
   task automatic send(input logic [DW-1:0] d, input bit sof, input int gap);
      int guard = 0;
      pix_in = d; pix_in_sof = sof; pix_in_valid = 1'b1;
      @(negedge clk);
      while (!pix_in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) chk("ready_timeout", 0, 1);
      @(posedge clk); #1;
      pix_in_valid = 1'b0; pix_in_sof = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   // mode 0: 16*row+col continuous, 1: same with 1-cycle gaps, 2: random data and gaps
   task automatic send_frame(input int mode, input int npix);
      for (int i = 0; i < npix; i++) begin
         logic [DW-1:0] d;
         int gap;
         d   = (mode == 2) ? DW'($urandom_range(0, 255)) : DW'(16 * (i / W) + (i % W));
         gap = (mode == 1) ? 1 : ((mode == 2) ? int'($urandom_range(0, 2)) : 0);
         send(d, (i == 0), gap);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_reset = 1'b1;
      #1;
      check_zero();
      wq.delete(); sq.delete();
      m_phase = 0; exp_fd = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1; in_reset = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_zero();
      rst_n = 1'b1; in_reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) send(8'hAA, 1'b0, 0);
      send_frame(0, W * H);
      send_frame(1, W * H);
      repeat (6) begin @(posedge clk); #1; end
      send_frame(2, W * H);
      send_frame(0, W * H);
      send_frame(2, 9);
      send_frame(2, W * H);
      repeat (8) begin @(posedge clk); #1; end
      send_frame(0, 11);
      #1;
      do_reset();
      send_frame(0, W * H);
      for (int f = 0; f < 3; f++) send_frame(2, W * H);

      repeat (W + 12) @(posedge clk);
      #1;
      chk("win_queue_empty", wq.size(), 0);
      chk("shift_queue_empty", sq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
